alu_cmd_sequencer: RTL

- Front-end controller for the 8-bit ALU (proj1_alu: 8-bit opcode, 8-bit rr/rd operands, carry-in, 16-bit result, C/Z/N flags).
- Accepts ALU commands from requesters through a valid/ready port and queues them in a small FIFO.
- Issues queued commands to the ALU one at a time, waits the ALU latency, then captures the result and flags.
- Returns each result on a valid/ready response port with a wrapping sequence tag.

---
 rtl/alu_cmd_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// ALU command front-end: command FIFO, issue/wait/respond FSM, tagged responses.
// Optional ALU_SEQ_CARRY_CHAIN_EN chains alu_co into the next issued alu_ci.
module alu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_opcode,
  input  logic [7:0]       cmd_rr,
  input  logic [7:0]       cmd_rd,
  input  logic             cmd_ci,
  output logic [7:0]       alu_opcode,
  output logic [7:0]       alu_rr,
  output logic [7:0]       alu_rd,
  output logic             alu_ci,
  input  logic [15:0]      alu_data,
  input  logic             alu_co,
  input  logic             alu_zo,
  input  logic             alu_no,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_n,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  localparam int EW = 24;
`else
  localparam int EW = 25;
`endif

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state, nxt;

  logic [EW-1:0]    mem [DEPTH];
  logic [EW-1:0]    head;
  logic [EW-1:0]    wdata;
  logic [AW:0]      wp, rp;
  logic             full, empty, push, pop, cap;
  logic [CW-1:0]    cnt;
  logic [TAG_W-1:0] tag;

  // Extra pointer bit distinguishes full from empty.
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = mem[rp[AW-1:0]];
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign wdata = {cmd_opcode, cmd_rr, cmd_rd};
`else
  assign wdata = {cmd_ci, cmd_opcode, cmd_rr, cmd_rd};
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    pop = 1'b0;
    cap = 1'b0;
    unique case (state)
      IDLE:  if (!empty) nxt = ISSUE;
      ISSUE: begin
        pop = 1'b1;
        nxt = WAIT;
      end
      WAIT: if (cnt == '0) begin
        cap = 1'b1;
        nxt = RESP;
      end
      RESP: if (rsp_ready) nxt = empty ? IDLE : ISSUE;
      default: nxt = IDLE;
    endcase
  end

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  logic carry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     carry <= 1'b0;
    else if (cap) carry <= alu_co;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_opcode <= '0;
      alu_rr     <= '0;
      alu_rd     <= '0;
      alu_ci     <= 1'b0;
      cnt        <= '0;
    end else if (pop) begin
      alu_opcode <= head[23:16];
      alu_rr     <= head[15:8];
      alu_rd     <= head[7:0];
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      alu_ci     <= carry;
`else
      alu_ci     <= head[24];
`endif
      cnt        <= CW'(ALU_LAT - 1);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_data <= '0;
      rsp_c    <= 1'b0;
      rsp_z    <= 1'b0;
      rsp_n    <= 1'b0;
      rsp_tag  <= '0;
      tag      <= '0;
    end else if (cap) begin
      rsp_data <= alu_data;
      rsp_c    <= alu_co;
      rsp_z    <= alu_zo;
      rsp_n    <= alu_no;
      rsp_tag  <= tag;
      tag      <= tag + 1'b1;
    end
  end

endmodule
